// File: rtl/fft_test_controller.sv
// ============================================================================
//  Module   : fft_test_controller
//  Brief    : Programmable trigger pacing plus AXIS frame checker and capture buffer
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fft_test_controller #(
    parameter int NB_DATA   = 12,
    parameter int N_POINT   = 8,
    parameter int N_FRAMES  = 2,
    parameter int NB_PERIOD = 12,
    parameter int NB_FCOUNT = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_enable,
    input  logic [NB_PERIOD-1:0]                  i_period,
    input  logic                                  i_mode,
    input  logic                                  i_arm,
    output logic                                  o_gen_valid,
    input  logic [2*NB_DATA-1:0]                  s_axis_data_tdata,
    input  logic                                  s_axis_data_tvalid,
    input  logic                                  s_axis_data_tlast,
    output logic                                  s_axis_data_tready,
    input  logic [$clog2(N_POINT*N_FRAMES)-1:0]   i_rd_addr,
    output logic [2*NB_DATA-1:0]                  o_rd_data,
    output logic [NB_FCOUNT-1:0]                  o_frame_count,
    output logic [7:0]                            o_err_count,
    output logic                                  o_busy,
    output logic                                  o_done
);

    localparam int DEPTH = N_POINT * N_FRAMES;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(N_POINT);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N_POINT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 state_q;
    logic [AW-1:0]          wp_q;
    logic [IW-1:0]          idx_q;
    logic [NB_PERIOD-1:0]   cnt_q;
    logic                   gen_q;
    logic                   tready_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NB_FCOUNT-1:0]   fcount_q;
    logic [7:0]             err_q;
    logic [2*NB_DATA-1:0]   rd_q;
    logic [2*NB_DATA-1:0]   mem_q [DEPTH];

    logic                   w_accept;
    logic                   w_pace_ok;
    logic                   w_frame_err;
    logic                   w_wr_en;
    logic [AW-1:0]          w_wr_addr;

    assign w_accept    = s_axis_data_tvalid && tready_q;
    assign w_pace_ok   = !i_mode || busy_q;
    assign w_frame_err = w_accept &&
                         (s_axis_data_tlast ? (idx_q != LAST_IDX) : (idx_q == LAST_IDX));

    // A restart pulse wins over a beat arriving in the same cycle.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = wp_q;
        if (w_accept && !i_arm) begin
            if (state_q == ST_ARMED && idx_q == '0) begin
                w_wr_en   = 1'b1;
                w_wr_addr = '0;
            end else if (state_q == ST_CAPTURE) begin
                w_wr_en   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            gen_q <= 1'b0;
        end else if (i_enable && w_pace_ok) begin
            if (cnt_q == i_period) begin
                cnt_q <= '0;
                gen_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                gen_q <= 1'b0;
            end
        end else begin
            cnt_q <= '0;
            gen_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tready_q <= 1'b0;
            idx_q    <= '0;
            fcount_q <= '0;
            err_q    <= '0;
        end else begin
            tready_q <= 1'b1;
            if (w_accept) begin
                if (s_axis_data_tlast) begin
                    idx_q    <= '0;
                    fcount_q <= fcount_q + 1'b1;
                end else begin
                    idx_q    <= idx_q + 1'b1;
                end
            end
            if (w_frame_err && err_q != 8'hFF) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_arm) begin
                        state_q <= ST_ARMED;
                        wp_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (i_arm) begin
                        wp_q <= '0;
                    end else if (w_accept && idx_q == '0) begin
                        state_q <= ST_CAPTURE;
                        wp_q    <= AW'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (i_arm) begin
                        state_q <= ST_ARMED;
                        wp_q    <= '0;
                    end else if (w_accept) begin
                        if (wp_q == LAST_ADDR) begin
                            wp_q <= '0;
                            if (i_mode) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            wp_q <= wp_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_arm) begin
                        state_q <= ST_ARMED;
                        wp_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer array is left unreset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            mem_q[w_wr_addr] <= s_axis_data_tdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem_q[i_rd_addr];
        end
    end

    assign o_gen_valid        = gen_q;
    assign s_axis_data_tready = tready_q;
    assign o_rd_data          = rd_q;
    assign o_frame_count      = fcount_q;
    assign o_err_count        = err_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_test_controller.sv
// ============================================================================
//  Module   : tb_fft_test_controller
//  Brief    : Self-checking bench for fft_test_controller (read-back scoreboard)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fft_test_controller;

    localparam int NB_DATA = 12;
    localparam int DEPTH   = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic [11:0]          period;
    logic                 mode;
    logic                 arm;
    logic                 gen_valid;
    logic [23:0]          tdata;
    logic                 tvalid;
    logic                 tlast;
    logic                 tready;
    logic [3:0]           rd_addr;
    logic [23:0]          rd_data;
    logic [15:0]          frame_count;
    logic [7:0]           err_count;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] sb_q[$];
    logic [23:0] exp_buf [DEPTH];

    fft_test_controller #(
        .NB_DATA  (NB_DATA),
        .N_POINT  (8),
        .N_FRAMES (2),
        .NB_PERIOD(12),
        .NB_FCOUNT(16)
    ) u_dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_enable           (enable),
        .i_period           (period),
        .i_mode             (mode),
        .i_arm              (arm),
        .o_gen_valid        (gen_valid),
        .s_axis_data_tdata  (tdata),
        .s_axis_data_tvalid (tvalid),
        .s_axis_data_tlast  (tlast),
        .s_axis_data_tready (tready),
        .i_rd_addr          (rd_addr),
        .o_rd_data          (rd_data),
        .o_frame_count      (frame_count),
        .o_err_count        (err_count),
        .o_busy             (busy),
        .o_done             (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] beat_word(input int b);
        return {12'(b + 256), 12'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_gen",    32'(gen_valid),   0);
        chk("rst_tready", 32'(tready),      0);
        chk("rst_rddata", 32'(rd_data),     0);
        chk("rst_fcount", 32'(frame_count), 0);
        chk("rst_err",    32'(err_count),   0);
        chk("rst_busy",   32'(busy),        0);
        chk("rst_done",   32'(done),        0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rel_tready", 32'(tready), 1);
    endtask

    task automatic send_beat(input int b, input logic last, input logic arm_now);
        tdata  = beat_word(b);
        tvalid = 1'b1;
        tlast  = last;
        arm    = arm_now;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
        arm    = 1'b0;
    endtask

    // Expected word is queued as the address is driven and retired one clock later.
    task automatic rd(input int a, input logic [23:0] exp);
        logic [23:0] e;
        rd_addr = 4'(a);
        sb_q.push_back(exp);
        tick();
        e = sb_q.pop_front();
        chk($sformatf("rd[%0d]", a), 32'(rd_data), 32'(e));
    endtask

    initial begin
        int   first;
        int   last_p;
        int   npulse;
        logic any;

        rst_n   = 1'b0;
        enable  = 1'b0;
        period  = '0;
        mode    = 1'b0;
        arm     = 1'b0;
        tdata   = '0;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        rd_addr = '0;

        // ---- pacing
        do_reset();
        enable = 1'b1;
        period = 12'd4;
        first  = -1;
        last_p = -1;
        npulse = 0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            if (gen_valid) begin
                if (last_p >= 0) chk("gen_gap", 32'(c - last_p), 5);
                else first = c;
                last_p = c;
                npulse++;
            end
        end
        chk("gen_first", 32'(first), 5);
        chk("gen_count", 32'(npulse), 4);
        enable = 1'b0;
        tick();
        chk("gen_disable", 32'(gen_valid), 0);
        enable = 1'b1;
        any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            any = any | gen_valid;
        end
        chk("gen_cleared_quiet", 32'(any), 0);
        tick();
        chk("gen_cleared_pulse", 32'(gen_valid), 1);
        enable = 1'b0;
        tick();
        period = 12'd0;
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("gen_period0", 32'(gen_valid), 1);
        end

        // ---- single-shot capture, armed mid-frame
        do_reset();
        mode   = 1'b1;
        enable = 1'b1;
        period = 12'd0;
        tick();
        tick();
        chk("gen_idle_mode1", 32'(gen_valid), 0);
        for (int b = 0; b < 32; b++) begin
            send_beat(b, (b % 8) == 7, b == 3);
            if (b == 5) begin
                chk("ss_gen_armed", 32'(gen_valid), 1);
                chk("ss_busy",      32'(busy),      1);
                chk("ss_done0",     32'(done),      0);
            end
            if (b == 23) begin
                chk("ss_done",      32'(done), 1);
                chk("ss_busy_done", 32'(busy), 0);
            end
            if (b == 25) chk("ss_gen_done", 32'(gen_valid), 0);
        end
        chk("ss_done_hold", 32'(done),        1);
        chk("ss_fcount",    32'(frame_count), 4);
        chk("ss_err",       32'(err_count),   0);
        for (int a = 0; a < DEPTH; a++) rd(a, beat_word(8 + a));

        // ---- framing errors
        do_reset();
        for (int b = 0; b < 6; b++) send_beat(b, b == 5, 1'b0);
        chk("fe_err_early", 32'(err_count),   1);
        chk("fe_fc_early",  32'(frame_count), 1);
        for (int b = 0; b < 8; b++) send_beat(b, 1'b0, 1'b0);
        chk("fe_err_miss",  32'(err_count),   2);
        chk("fe_fc_miss",   32'(frame_count), 1);
        for (int b = 0; b < 8; b++) send_beat(b, b == 7, 1'b0);
        chk("fe_err_clean", 32'(err_count),   2);
        chk("fe_fc_clean",  32'(frame_count), 2);

        // ---- continuous ring capture
        do_reset();
        mode = 1'b0;
        arm  = 1'b1;
        tick();
        arm  = 1'b0;
        for (int b = 0; b < 24; b++) send_beat(b, (b % 8) == 7, 1'b0);
        chk("ring_done", 32'(done), 0);
        chk("ring_busy", 32'(busy), 1);
        for (int a = 0; a < DEPTH; a++) exp_buf[a] = beat_word(a < 8 ? a + 16 : a);
        for (int a = 0; a < DEPTH; a++) rd(a, exp_buf[a]);
        chk("ring_busy_after", 32'(busy), 1);

        // ---- restart during capture, then asynchronous reset
        do_reset();
        mode   = 1'b1;
        enable = 1'b1;
        period = 12'd0;
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
        for (int b = 0; b < 6; b++) send_beat(100 + b, 1'b0, 1'b0);
        send_beat(106, 1'b0, 1'b1);
        chk("rs_busy_rearm", 32'(busy), 1);
        send_beat(107, 1'b1, 1'b0);
        for (int b = 8; b < 11; b++) send_beat(100 + b, 1'b0, 1'b0);
        rd(0, beat_word(108));
        rd(1, beat_word(109));
        rd(2, beat_word(110));
        rd(5, beat_word(105));
        chk("rs_fcount_pre", 32'(frame_count), 1);
        chk("rs_gen_pre",    32'(gen_valid),   1);
        do_reset();
        chk("rs_busy_post", 32'(busy), 0);
        for (int b = 0; b < 8; b++) send_beat(b, b == 7, 1'b0);
        chk("rs_idle_busy", 32'(busy),      0);
        chk("rs_idle_gen",  32'(gen_valid), 0);
        chk("rs_idle_fc",   32'(frame_count), 1);

        // ---- error counter saturation
        do_reset();
        enable = 1'b0;
        for (int f = 0; f < 300; f++) begin
            for (int b = 0; b < 4; b++) send_beat(b, b == 3, 1'b0);
            if (f == 253) chk("sat_err_254", 32'(err_count), 254);
        end
        chk("sat_err",    32'(err_count),   255);
        chk("sat_fcount", 32'(frame_count), 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_test_controller.md
Name: fft_test_controller

Overview:
Next-generation bring-up controller for the FFT test harness. It paces the signal generator with a runtime-programmable trigger period, replacing the fixed COUNT_MAX counter. It also acts as the AXIS sink for FFT output frames: it checks frame framing against tlast and captures whole frames into an on-chip buffer that can be read back. This gives a self-contained capture path for bench, VIO and eventual silicon readout.

Parameters:
NB_DATA, 12, width of each real/imag component of the FFT output
N_POINT, 8, samples per FFT frame (power of two, >=2)
N_FRAMES, 2, frames held by the capture buffer (power of two, >=1)
NB_PERIOD, 12, width of the pacing period input
NB_FCOUNT, 16, width of the frame counter

Ports:
i_clk  in  1  clock; all logic is rising-edge
i_rst_n  in  1  asynchronous, active-low reset
i_enable  in  1  enables the pacing counter
i_period  in  NB_PERIOD  pacing period: one trigger every i_period+1 cycles
i_mode  in  1  0 = continuous ring capture, 1 = single-shot capture
i_arm  in  1  single-cycle pulse; starts or restarts a capture
o_gen_valid  out  1  one-cycle trigger pulse to the signal generator
s_axis_data_tdata  in  2*NB_DATA  {real, imag} FFT output beat
s_axis_data_tvalid  in  1  beat valid
s_axis_data_tlast  in  1  last beat of a frame
s_axis_data_tready  out  1  sink ready
i_rd_addr  in  log2(N_POINT*N_FRAMES)  buffer read address
o_rd_data  out  2*NB_DATA  buffer read data, one-cycle latency
o_frame_count  out  NB_FCOUNT  count of accepted tlast beats, wraps
o_err_count  out  8  count of framing errors, saturates at 255
o_busy  out  1  FSM in ARMED or CAPTURE
o_done  out  1  single-shot capture complete

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - FSM = IDLE; pacing counter, write pointer and beat index = 0.
  - All outputs 0, including s_axis_data_tready and o_rd_data.
  - Buffer contents undefined.
- s_axis_data_tready is registered: 0 in reset, 1 from the first clock after release. No backpressure is ever applied. A beat is accepted when tvalid && tready.
- Pacing counter:
  - Counts while i_enable=1 and pacing is permitted.
  - When counter == i_period: o_gen_valid=1 for that cycle and the counter returns to 0. Otherwise counter+1 and o_gen_valid=0.
  - i_period=0 gives o_gen_valid high every cycle.
  - i_enable=0 or pacing not permitted: counter cleared, o_gen_valid=0.
  - Pacing is permitted always when i_mode=0, and only in ARMED or CAPTURE when i_mode=1.
  - If i_period changes mid-count, the comparison uses the new value. If the counter is already above the new period, it counts up and wraps at 2^NB_PERIOD.
- Beat index (0..N_POINT-1):
  - Tracked on every accepted beat in all states.
  - Accepted beat with tlast: index <= 0, o_frame_count+1.
  - Accepted beat without tlast: index+1, wrapping at N_POINT.
  - Framing error, o_err_count+1 saturating: tlast at index != N_POINT-1, or no tlast at index == N_POINT-1.
- FSM:
  - IDLE: accepted beats are discarded. i_arm -> ARMED with write pointer = 0.
  - ARMED: beats are discarded until an accepted beat arrives with index==0. That beat is written at address 0, the write pointer becomes 1, and the FSM moves to CAPTURE in the same cycle.
  - CAPTURE: each accepted beat is written at the write pointer, then the pointer increments. When the beat at address N_POINT*N_FRAMES-1 is written:
    - i_mode=1: go to DONE with o_done=1.
    - i_mode=0: pointer wraps to 0 and the FSM stays in CAPTURE.
  - DONE: o_done held at 1, buffer frozen. i_arm -> ARMED and o_done clears.
  - i_arm while in ARMED or CAPTURE: restart to ARMED, pointer = 0. A beat in that same cycle is not written.
  - i_mode is sampled continuously. A change takes effect at the next buffer-end decision.
- o_busy = (state==ARMED || state==CAPTURE), registered along with the state.
- Read port:
  - Synchronous read; o_rd_data updates on the clock after i_rd_addr is presented.
  - Reading and writing the same address in one cycle returns the old data.
- Reset mid-capture: immediate return to IDLE. A new i_arm is required to capture.

Test Plan:
- Reset, then i_enable=1 and i_period=4, i_mode=0: o_gen_valid pulses exactly every 5 cycles. Setting i_enable=0 gives no pulse on the next cycle and the counter is cleared. i_period=0 gives o_gen_valid continuously high.
- i_mode=1, arm mid-frame at index 3, then stream frames with data = beat number 0..31: capture starts at the next index-0 beat. After 16 beats o_done=1 and o_busy=0. Reading addresses 0..15 returns the 16 captured beats in arrival order, each one cycle after its address.
- Inject tlast at index 5 of one frame, then omit tlast at index 7 of the next frame: o_err_count=2. The index realigns after the early tlast. o_frame_count counts only accepted tlast beats.
- i_mode=0 with 3 full frames (24 beats): the buffer wraps and holds beats 8..23. o_done stays 0 and o_busy stays 1.
- Pulse i_arm during CAPTURE at write pointer 6: the FSM returns to ARMED and the next index-0 beat is written at address 0. Assert i_rst_n=0 mid-capture: all outputs go to 0 asynchronously, and after release the FSM is in IDLE with s_axis_data_tready=1 one clock later.
- Feed 300 frames each containing a framing error: o_err_count saturates at 255 while o_frame_count keeps counting.
